// File: rtl/seg7_count_decoder.sv
// Seven-segment receive monitor: debounces the segment bus, decodes accepted patterns and
// checks for +1 steps. Define SEG7_DEC_HEX_EN to accept A-F (modulus 16 instead of 10).
module seg7_count_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           encoded_count,
  output logic [3:0]           digit,
  output logic                 digit_valid,
  output logic                 blank,
  output logic                 new_digit,
  output logic                 invalid_pattern,
  output logic                 step_error,
  output logic [ERR_CNT_W-1:0] error_count
);

  localparam int unsigned CntW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
`ifdef SEG7_DEC_HEX_EN
  localparam logic [3:0] LastDigit = 4'd15;
`else
  localparam logic [3:0] LastDigit = 4'd9;
`endif

  typedef enum logic [1:0] {StSettling, StAccept, StLocked} state_e;

  // Returns {valid, digit}; blank and unknown patterns both report valid=0.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'h3F:   decode = {1'b1, 4'd0};
      7'h06:   decode = {1'b1, 4'd1};
      7'h5B:   decode = {1'b1, 4'd2};
      7'h4F:   decode = {1'b1, 4'd3};
      7'h66:   decode = {1'b1, 4'd4};
      7'h6D:   decode = {1'b1, 4'd5};
      7'h7D:   decode = {1'b1, 4'd6};
      7'h07:   decode = {1'b1, 4'd7};
      7'h7F:   decode = {1'b1, 4'd8};
      7'h6F:   decode = {1'b1, 4'd9};
`ifdef SEG7_DEC_HEX_EN
      7'h77:   decode = {1'b1, 4'd10};
      7'h7C:   decode = {1'b1, 4'd11};
      7'h39:   decode = {1'b1, 4'd12};
      7'h5E:   decode = {1'b1, 4'd13};
      7'h79:   decode = {1'b1, 4'd14};
      7'h71:   decode = {1'b1, 4'd15};
`endif
      default: decode = 5'b0;
    endcase
  endfunction

  state_e          state_q;
  logic [6:0]      s_reg_q;
  logic [6:0]      last_q;
  logic [CntW-1:0] cnt_q;
  logic            armed_q;
  logic            acc_any_q;

  logic            sample_match;
  logic            accept_now;
  logic            repeat_pat;
  logic [4:0]      dec;
  logic [3:0]      succ;

  always_comb begin
    sample_match = (encoded_count == s_reg_q);
    accept_now   = (state_q == StSettling) && (cnt_q == CntMax);
    repeat_pat   = acc_any_q && (s_reg_q == last_q);
    dec          = decode(s_reg_q);
    succ         = (digit == LastDigit) ? 4'd0 : digit + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StSettling;
      s_reg_q         <= 7'h00;
      last_q          <= 7'h00;
      cnt_q           <= '0;
      armed_q         <= 1'b0;
      acc_any_q       <= 1'b0;
      digit           <= 4'd0;
      digit_valid     <= 1'b0;
      blank           <= 1'b0;
      new_digit       <= 1'b0;
      invalid_pattern <= 1'b0;
      step_error      <= 1'b0;
      error_count     <= '0;
    end else begin
      s_reg_q         <= encoded_count;
      new_digit       <= 1'b0;
      invalid_pattern <= 1'b0;
      step_error      <= 1'b0;

      if (!sample_match) begin
        cnt_q <= CntW'(1);
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + CntW'(1);
      end

      unique case (state_q)
        StSettling: if (accept_now && sample_match) state_q <= StAccept;
        StAccept:   state_q <= sample_match ? StLocked : StSettling;
        StLocked:   if (!sample_match) state_q <= StSettling;
        default:    state_q <= StSettling;
      endcase

      if (accept_now) begin
        last_q    <= s_reg_q;
        acc_any_q <= 1'b1;
      end

      // Re-accepting the same pattern after a rejected glitch is silent.
      if (accept_now && !repeat_pat) begin
        if (dec[4]) begin
          digit       <= dec[3:0];
          digit_valid <= 1'b1;
          blank       <= 1'b0;
          new_digit   <= 1'b1;
          armed_q     <= 1'b1;
          if (armed_q && (dec[3:0] != succ)) begin
            step_error <= 1'b1;
            if (error_count != '1) error_count <= error_count + ERR_CNT_W'(1);
          end
        end else if (s_reg_q == 7'h00) begin
          blank       <= 1'b1;
          digit_valid <= 1'b0;
          armed_q     <= 1'b0;
        end else begin
          invalid_pattern <= 1'b1;
          digit_valid     <= 1'b0;
          blank           <= 1'b0;
          armed_q         <= 1'b0;
          if (error_count != '1) error_count <= error_count + ERR_CNT_W'(1);
        end
      end
    end
  end

endmodule
